instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch stage upstream of the instruction memory. Owns the program counter: drives `imem_pc` to the combinational instruction memory, captures the returned word together with its PC into a 2-entry fetch queue, and presents entries to the decode stage over a valid/ready handshake. Handles branch/jump redirect with a queue flush, and a halt request that freezes fetching.

## Interface
- `PC_W`, 16, program-counter width; the PC is a byte address.
- `INSTR_W`, 16, instruction word width.
- `RESET_PC`, 16'h0000, PC value after reset; bit 0 must be 0.
- `PC_STEP`, 2, PC increment per fetched word.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_pc`  out  PC_W  fetch address to instruction memory (registered `pc_q`).
- `imem_instr`  in  INSTR_W  combinational memory data for `imem_pc`, sampled the same cycle.
- `redirect_valid`  in  1  one-cycle request to load a new PC (branch/jump taken).
- `redirect_pc`  in  PC_W  redirect target.
- `halt_req`  in  1  level; while high, no new fetches.
- `id_valid`  out  1  queue head valid toward decode.
- `id_ready`  in  1  decode accepts head this cycle.
- `id_instr`  out  INSTR_W  head instruction.
- `id_pc`  out  PC_W  PC of head instruction.
- `halted`  out  1  high while the FSM is in HALTED.
- `align_err`  out  1  sticky; set by a redirect with `redirect_pc[0]=1`.

## Operation
- FSM states: FETCH, HALTED. Reset state FETCH.
- FETCH→HALTED when `halt_req=1` and no redirect. HALTED→FETCH when `halt_req=0`, or on any redirect.
- Fetch condition (FETCH, no redirect, `halt_req=0`): queue count < 2, or count = 2 with head popped this cycle. On fetch: enqueue {`pc_q`, `imem_instr`}; `pc_q <= pc_q + PC_STEP`, modulo 2^PC_W (16'hFFFE → 16'h0000).
- Pop: `id_valid && id_ready` removes the head. Push and pop in the same cycle leave count unchanged.
- Redirect (any state): queue count → 0, `id_valid` low next cycle, `pc_q <= {redirect_pc[PC_W-1:1],1'b0}`, no enqueue that cycle; a simultaneous pop is discarded along with the flush. If `redirect_pc[0]=1`, `align_err` sets and remains set until reset.
- Priority: reset > redirect > halt > fetch.
- HALTED: `pc_q` frozen; queued entries still drain to decode.
- Queue entries hold; `id_instr`/`id_pc` are stable while `id_valid=1 && id_ready=0`.
- The memory aliases addresses beyond its depth (it decodes only low PC bits); no range check here.

## Timing
- Reset values: `pc_q`/`imem_pc`=RESET_PC, `id_valid`=0, `id_instr`=0, `id_pc`=0, `halted`=0, `align_err`=0, queue count 0.
- First fetch occurs in the first clock edge after `rst_n` rises; `id_valid`=1 one cycle later.
- Fetch-to-decode latency: 1 cycle (word fetched at edge N is at the head after N).
- Throughput: 1 instruction/cycle with `id_ready` held high.
- Redirect at edge N: `imem_pc`=target after N; target instruction on `id_*` after N+1.
- `halt_req` rising at edge N: no enqueue at N; `halted`=1 after N.
- `rst_n` low mid-operation: all state cleared immediately, independent of `clk`.

## Structure
- Shared `Parameter.v`: PC_W, INSTR_W, RESET_PC, PC_STEP defaults; FSM state encodings (FETCH=1'b0, HALTED=1'b1).
- Sub-module `fetch_queue`: 2-entry FIFO of {pc, instr}, with push, pop, and flush inputs and a count output; flush takes priority over push and pop.
- Top: PC register, FSM, fetch/redirect logic.

## Test plan
- Reset, `id_ready`=1, memory word k = 16'h1000+k → `imem_pc` 0,2,4,…; `id_pc`/`id_instr` = 0/1000, 2/1001, 4/1002, … on consecutive cycles, first one cycle after reset release.
- `id_ready`=0 for 4 cycles after the first valid → queue fills at 2 entries; `imem_pc` stops at 16'h0004; the head stays at 0/1000; on release, the sequence continues with no loss or duplication.
- Redirect to 16'h0020 while the queue is full and `id_ready`=1 → `id_valid`=0 next cycle; the next valid `id_pc`=16'h0020, with no stale 16'h0004/0006 entries.
- Redirect to 16'h0031 → `align_err`=1 (sticky), fetch resumes at 16'h0030.
- `halt_req` high for 5 cycles with 2 queued entries → both entries drain, `halted`=1, `imem_pc` frozen; `halt_req` low → `halted`=0 and fetch resumes from the frozen PC.
- Start at `pc_q`=16'hFFFC via redirect → fetched PCs FFFC, FFFE, 0000, 0002; assert `rst_n`=0 mid-stream → all outputs reach their reset values before the next edge.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared defaults and FSM encoding for the fetch stage
package instruction_fetch_unit_pkg;
  localparam int PC_W_DEF = 16;
  localparam int INSTR_W_DEF = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam int PC_STEP_DEF = 2;
  typedef enum logic {FETCH = 1'b0, HALTED = 1'b1} state_e;
endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// fetch_queue: 2-entry {pc, instr} FIFO with flush overriding push and pop
module fetch_queue
  import instruction_fetch_unit_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [PC_W-1:0]    push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic               pop,
  input  logic               flush,
  output logic [1:0]         count,
  output logic [PC_W-1:0]    head_pc,
  output logic [INSTR_W-1:0] head_instr
);
  logic [PC_W-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [INSTR_W-1:0] in0_q, in0_d, in1_q, in1_d;
  logic [1:0] count_q, count_d, left;
  logic do_pop, do_push;
  always_comb begin
    do_pop = pop && count_q != 2'd0;
    left = count_q - {1'b0, do_pop};
    do_push = push && left != 2'd2;
    pc0_d = do_pop ? pc1_q : pc0_q;
    in0_d = do_pop ? in1_q : in0_q;
    pc1_d = pc1_q;
    in1_d = in1_q;
    if (do_push && left == 2'd0) begin
      pc0_d = push_pc;
      in0_d = push_instr;
    end
    if (do_push && left == 2'd1) begin
      pc1_d = push_pc;
      in1_d = push_instr;
    end
    count_d = flush ? 2'd0 : left + {1'b0, do_push};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc0_q <= '0;
      pc1_q <= '0;
      in0_q <= '0;
      in1_q <= '0;
      count_q <= 2'd0;
    end else begin
      pc0_q <= pc0_d;
      pc1_q <= pc1_d;
      in0_q <= in0_d;
      in1_q <= in1_d;
      count_q <= count_d;
    end
  end
  assign count = count_q;
  assign head_pc = pc0_q;
  assign head_instr = in0_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC register, fetch/halt FSM and redirect handling feeding decode
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
  parameter int PC_STEP = PC_STEP_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt_req,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  output logic               halted,
  output logic               align_err
);
  state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic align_err_q, align_err_d;
  logic [1:0] count;
  logic pop, fetch;
  always_comb begin
    pop = id_valid && id_ready;
    fetch = state_q == FETCH && !redirect_valid && !halt_req && (count != 2'd2 || pop);
    state_d = (halt_req && !redirect_valid) ? HALTED : FETCH;
    pc_d = redirect_valid ? {redirect_pc[PC_W-1:1], 1'b0} : fetch ? pc_q + PC_W'(PC_STEP) : pc_q;
    align_err_d = align_err_q || (redirect_valid && redirect_pc[0]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      align_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      align_err_q <= align_err_d;
    end
  end
  fetch_queue #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_queue (
    .clk(clk),
    .rst_n(rst_n),
    .push(fetch),
    .push_pc(pc_q),
    .push_instr(imem_instr),
    .pop(pop),
    .flush(redirect_valid),
    .count(count),
    .head_pc(id_pc),
    .head_instr(id_instr)
  );
  assign imem_pc = pc_q;
  assign id_valid = count != 2'd0;
  assign halted = state_q == HALTED;
  assign align_err = align_err_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed plan plus random traffic against a queue-based model
module tb_instruction_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] imem_pc, imem_instr, redirect_pc, id_instr, id_pc;
  logic redirect_valid = 1'b0, halt_req = 1'b0, id_ready = 1'b0;
  logic id_valid, halted, align_err;
  typedef struct {logic [15:0] pc; logic [15:0] instr;} ent_t;
  ent_t q[$];
  logic [15:0] mpc;
  bit mhalt, merr;
  int vectors = 0, errs = 0;

  always #5 clk = ~clk;
  assign imem_instr = 16'h1000 + {1'b0, imem_pc[15:1]};

  instruction_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .halted(halted), .align_err(align_err)
  );

  function automatic logic [15:0] word(input logic [15:0] pc);
    return 16'h1000 + {1'b0, pc[15:1]};
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h, want %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic compare();
    chk("imem_pc", imem_pc, mpc);
    chk("id_valid", id_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("id_pc", id_pc, q[0].pc);
      chk("id_instr", id_instr, q[0].instr);
    end
    chk("halted", halted, mhalt);
    chk("align_err", align_err, merr);
  endtask

  task automatic model_reset();
    q.delete();
    mpc = 16'h0000;
    mhalt = 0;
    merr = 0;
  endtask

  task automatic step(input bit rdy, input bit rv, input logic [15:0] rpc, input bit hlt);
    bit pop;
    id_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    halt_req = hlt;
    pop = q.size() > 0 && rdy;
    if (rv) begin
      q.delete();
      merr |= rpc[0];
      mpc = rpc & 16'hFFFE;
      mhalt = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (hlt) mhalt = 1;
      else begin
        if (!mhalt && q.size() < 2) begin
          q.push_back('{mpc, word(mpc)});
          mpc = mpc + 16'd2;
        end
        mhalt = 0;
      end
    end
    @(posedge clk);
    #1;
    compare();
    @(negedge clk);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_imem_pc", imem_pc, 16'h0000);
    chk("rst_id_valid", id_valid, 1'b0);
    chk("rst_id_pc", id_pc, 16'h0000);
    chk("rst_id_instr", id_instr, 16'h0000);
    chk("rst_halted", halted, 1'b0);
    chk("rst_align_err", align_err, 1'b0);
    @(posedge clk);
    #1;
    compare();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    redirect_pc = 16'h0000;
    model_reset();
    @(negedge clk);
    async_reset();
    step(1, 0, 0, 0);
    chk("lit_first_pc", id_pc, 16'h0000);
    chk("lit_first_instr", id_instr, 16'h1000);
    chk("lit_first_imem", imem_pc, 16'h0002);
    repeat (4) step(0, 0, 0, 0);
    chk("lit_stall_imem", imem_pc, 16'h0004);
    chk("lit_stall_head", id_pc, 16'h0000);
    step(1, 0, 0, 0);
    chk("lit_resume_head", id_pc, 16'h0002);
    step(1, 1, 16'h0020, 0);
    chk("lit_redir_valid", id_valid, 1'b0);
    chk("lit_redir_imem", imem_pc, 16'h0020);
    step(1, 0, 0, 0);
    chk("lit_redir_head", id_pc, 16'h0020);
    chk("lit_redir_instr", id_instr, 16'h1010);
    step(1, 1, 16'h0031, 0);
    chk("lit_align_err", align_err, 1'b1);
    chk("lit_align_imem", imem_pc, 16'h0030);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    repeat (5) step(1, 0, 0, 1);
    chk("lit_halt_state", halted, 1'b1);
    chk("lit_halt_imem", imem_pc, 16'h0034);
    chk("lit_halt_drained", id_valid, 1'b0);
    step(1, 0, 0, 0);
    chk("lit_unhalt_state", halted, 1'b0);
    chk("lit_unhalt_imem", imem_pc, 16'h0034);
    step(1, 0, 0, 0);
    chk("lit_unhalt_head", id_pc, 16'h0034);
    step(1, 1, 16'hFFFC, 0);
    step(1, 0, 0, 0);
    chk("lit_wrap_fffc", id_pc, 16'hFFFC);
    step(1, 0, 0, 0);
    chk("lit_wrap_fffe", id_pc, 16'hFFFE);
    step(1, 0, 0, 0);
    chk("lit_wrap_0000", id_pc, 16'h0000);
    chk("lit_wrap_instr", id_instr, 16'h1000);
    step(1, 0, 0, 0);
    chk("lit_wrap_0002", id_pc, 16'h0002);
    async_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) async_reset();
      else step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                16'($urandom), $urandom_range(0, 9) < 2 || (halt_req && $urandom_range(0, 3) != 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
